pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RISC-V core. Detects load-use hazards between ID and ID/EX, and collects stall requests from IF, the EX multi-cycle unit and the MEM data-memory handshake. Drives the 6-bit stall vector consumed by pc, if_id, id_ex_reg, ex_mem and mem_wb, plus bubble/flush controls. It also runs a memory-wait watchdog.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before watchdog fires (>=2)
CNT_WIDTH, 8, width of the internal wait counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
if_stall_req  in  1  IF cannot deliver an instruction this cycle
rs1_rd_en  in  1  ID reads rs1
rs2_rd_en  in  1  ID reads rs2
rs1_addr  in  5  ID rs1 index
rs2_addr  in  5  ID rs2 index
branch_taken  in  1  ID resolved taken branch/jump
mem_read_ex  in  1  instruction in ID/EX is a load
rd_addr_ex  in  5  destination of instruction in ID/EX
ex_busy  in  1  EX multi-cycle unit not done (level)
mem_req  in  1  MEM stage has a valid load/store
mem_ack  in  1  data memory completes access this cycle
stall  out  6  [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB; 1 = hold
id_ex_bubble  out  1  load NOP into ID/EX this edge
flush_if_id  out  1  clear IF/ID this edge (wrong-path fetch)
mem_timeout  out  1  sticky watchdog error flag

Behaviour:
- FSM states: RUN, MEM_WAIT. State, counter and mem_timeout are registered; stall, id_ex_bubble and flush_if_id are combinational from state and inputs.
- Reset (rst==0 at edge): state=RUN, counter=0, mem_timeout=0. While rst==0, stall=6'b000000, id_ex_bubble=0, flush_if_id=0.
- Hazard terms:
  - mem_stall = mem_req & ~mem_ack & ~wd_fire
  - load_use = mem_read_ex & (rd_addr_ex!=0) & ((rs1_rd_en & rs1_addr==rd_addr_ex) | (rs2_rd_en & rs2_addr==rd_addr_ex))
- Stall priority, highest first:
  - mem_stall -> 6'b011111
  - ex_busy -> 6'b001111
  - load_use -> 6'b000111, id_ex_bubble=1
  - if_stall_req -> 6'b000011
  - none -> 6'b000000
- id_ex_bubble asserts only when load_use is the winning source. Load-use costs exactly one cycle: after the bubble the load is in MEM and forwarding resolves the hazard.
- flush_if_id = branch_taken & ~stall[2]. A branch held in a stalled ID is not honoured until ID advances. Branch with if_stall_req is honoured: flush wins over the IF/IF-ID hold.
- RUN -> MEM_WAIT when mem_stall. Counter is set to 1.
- MEM_WAIT:
  - mem_ack -> RUN, counter=0. Stall drops in the same cycle as ack.
  - else counter++.
  - wd_fire = (state==MEM_WAIT) & (counter==MEM_TIMEOUT-1) & ~mem_ack. On wd_fire: stall released that cycle, mem_timeout<=1 (sticky until reset), state->RUN, counter=0.
- mem_req dropping without ack in MEM_WAIT -> RUN, counter=0, no error.
- Reset asserted mid-wait aborts the wait immediately with no error.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] (counts cycles with stall[0]==1) and bubble_count[31:0] (counts id_ex_bubble cycles). Both reset to 0, wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- lw x5 in EX (mem_read_ex=1, rd_addr_ex=5), ID add x6,x5,x1 (rs1_addr=5) -> one cycle stall=000111, id_ex_bubble=1; next cycle stall=000000.
- rd_addr_ex=0 with load, rs1_addr=0 -> no stall, no bubble.
- mem_req=1, mem_ack low 3 cycles then high -> stall=011111 for 3 cycles, 000000 on the ack cycle, mem_timeout=0.
- MEM_TIMEOUT=4, mem_req held, no ack -> stall=011111 for cycles 1-3, 000000 on cycle 4, mem_timeout=1 from the next cycle and stays 1 until rst=0.
- ex_busy=1 and load_use=1 and branch_taken=1 -> stall=001111, id_ex_bubble=0, flush_if_id=0; ex_busy drop -> 000111 + bubble.
- branch_taken=1 with if_stall_req=1 -> stall=000011, flush_if_id=1; rst=0 in MEM_WAIT -> all outputs 0, state RUN next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use detection, stall arbitration, IF/ID flush and MEM-wait watchdog.
// Optional STALL_PERF_CNT_EN adds stall_cycles / bubble_count performance counters.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_WIDTH   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       if_stall_req,
   input  logic       rs1_rd_en,
   input  logic       rs2_rd_en,
   input  logic [4:0] rs1_addr,
   input  logic [4:0] rs2_addr,
   input  logic       branch_taken,
   input  logic       mem_read_ex,
   input  logic [4:0] rd_addr_ex,
   input  logic       ex_busy,
   input  logic       mem_req,
   input  logic       mem_ack,
   output logic [5:0] stall,
   output logic       id_ex_bubble,
   output logic       flush_if_id,
   output logic       mem_timeout
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] bubble_count
`endif
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MEM_TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_t               state;
   state_t               state_nxt;
   logic [CNT_WIDTH-1:0] counter;
   logic [CNT_WIDTH-1:0] counter_nxt;
   logic                 timeout_q;
   logic                 timeout_set;
   logic                 wd_fire;
   logic                 mem_stall;
   logic                 load_use;
   logic                 rs1_hit;
   logic                 rs2_hit;

   // Watchdog only fires while the request is still pending; a dropped request is not an error.
   assign wd_fire   = (state == MEM_WAIT) & mem_req & ~mem_ack & (counter == CNT_LAST);
   assign mem_stall = mem_req & ~mem_ack & ~wd_fire;

   assign rs1_hit  = rs1_rd_en & (rs1_addr == rd_addr_ex);
   assign rs2_hit  = rs2_rd_en & (rs2_addr == rd_addr_ex);
   assign load_use = mem_read_ex & (rd_addr_ex != 5'd0) & (rs1_hit | rs2_hit);

   always_comb begin
      state_nxt    = state;
      counter_nxt  = counter;
      timeout_set  = 1'b0;
      stall        = 6'b000000;
      id_ex_bubble = 1'b0;
      flush_if_id  = 1'b0;

      case (state)
         RUN: begin
            if (mem_stall) begin
               state_nxt   = MEM_WAIT;
               counter_nxt = CNT_ONE;
            end
         end
         MEM_WAIT: begin
            if (mem_ack || !mem_req) begin
               state_nxt   = RUN;
               counter_nxt = '0;
            end else if (wd_fire) begin
               state_nxt   = RUN;
               counter_nxt = '0;
               timeout_set = 1'b1;
            end else begin
               counter_nxt = counter + CNT_ONE;
            end
         end
         default: begin
            state_nxt   = RUN;
            counter_nxt = '0;
         end
      endcase

      if (rst) begin
         if (mem_stall) begin
            stall = 6'b011111;
         end else if (ex_busy) begin
            stall = 6'b001111;
         end else if (load_use) begin
            stall        = 6'b000111;
            id_ex_bubble = 1'b1;
         end else if (if_stall_req) begin
            stall = 6'b000011;
         end
         // A branch sitting in a held ID stage waits until ID advances.
         flush_if_id = branch_taken & ~stall[2];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         counter   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         counter   <= counter_nxt;
         timeout_q <= timeout_q | timeout_set;
      end
   end

   assign mem_timeout = timeout_q & rst;

`ifdef STALL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cycles <= '0;
         bubble_count <= '0;
      end else begin
         if (stall[0]) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (id_ex_bubble) begin
            bubble_count <= bubble_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: single-cycle vector table plus multi-cycle sequences, MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

   typedef struct {
      string      name;
      logic       rst;
      logic       ifs;
      logic       r1e;
      logic       r2e;
      logic [4:0] r1a;
      logic [4:0] r2a;
      logic       br;
      logic       mrd;
      logic [4:0] rde;
      logic       exb;
      logic       mreq;
      logic       mack;
      logic [5:0] e_stall;
      logic       e_bub;
      logic       e_flush;
      logic       e_to;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       if_stall_req;
   logic       rs1_rd_en;
   logic       rs2_rd_en;
   logic [4:0] rs1_addr;
   logic [4:0] rs2_addr;
   logic       branch_taken;
   logic       mem_read_ex;
   logic [4:0] rd_addr_ex;
   logic       ex_busy;
   logic       mem_req;
   logic       mem_ack;
   logic [5:0] stall;
   logic       id_ex_bubble;
   logic       flush_if_id;
   logic       mem_timeout;
`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] bubble_count;
`endif

   int n_cmp = 0;
   int n_err = 0;
   vec_t exp_q[$];

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_stall_req (if_stall_req),
      .rs1_rd_en    (rs1_rd_en),
      .rs2_rd_en    (rs2_rd_en),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .branch_taken (branch_taken),
      .mem_read_ex  (mem_read_ex),
      .rd_addr_ex   (rd_addr_ex),
      .ex_busy      (ex_busy),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .stall        (stall),
      .id_ex_bubble (id_ex_bubble),
      .flush_if_id  (flush_if_id),
      .mem_timeout  (mem_timeout)
`ifdef STALL_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .bubble_count (bubble_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(string name, logic rs, logic ifs, logic r1e, logic [4:0] r1a,
                               logic r2e, logic [4:0] r2a, logic br, logic mrd, logic [4:0] rde,
                               logic exb, logic mreq, logic mack,
                               logic [5:0] es, logic eb, logic ef, logic et);
      vec_t v;
      v.name = name; v.rst = rs; v.ifs = ifs; v.r1e = r1e; v.r1a = r1a; v.r2e = r2e; v.r2a = r2a;
      v.br = br; v.mrd = mrd; v.rde = rde; v.exb = exb; v.mreq = mreq; v.mack = mack;
      v.e_stall = es; v.e_bub = eb; v.e_flush = ef; v.e_to = et;
      return v;
   endfunction

   task automatic check_one();
      vec_t e;
      if (exp_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard_empty: no expected record queued");
         return;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (stall !== e.e_stall) begin
         n_err++;
         $display("FAIL %s.stall: got %b want %b", e.name, stall, e.e_stall);
      end
      n_cmp++;
      if (id_ex_bubble !== e.e_bub) begin
         n_err++;
         $display("FAIL %s.bubble: got %b want %b", e.name, id_ex_bubble, e.e_bub);
      end
      n_cmp++;
      if (flush_if_id !== e.e_flush) begin
         n_err++;
         $display("FAIL %s.flush: got %b want %b", e.name, flush_if_id, e.e_flush);
      end
      n_cmp++;
      if (mem_timeout !== e.e_to) begin
         n_err++;
         $display("FAIL %s.timeout: got %b want %b", e.name, mem_timeout, e.e_to);
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, compare on the falling edge.
   task automatic apply(vec_t v);
      rst = v.rst; if_stall_req = v.ifs; rs1_rd_en = v.r1e; rs1_addr = v.r1a;
      rs2_rd_en = v.r2e; rs2_addr = v.r2a; branch_taken = v.br; mem_read_ex = v.mrd;
      rd_addr_ex = v.rde; ex_busy = v.exb; mem_req = v.mreq; mem_ack = v.mack;
      exp_q.push_back(v);
      @(negedge clk);
      check_one();
      @(posedge clk);
      #1;
   endtask

   // Shorthands: memory-only cycles and idle cycles.
   function automatic vec_t memc(string n, logic rs, logic mreq, logic mack,
                                 logic [5:0] es, logic et);
      return mk(n, rs, 0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, mreq, mack, es, 0, 0, et);
   endfunction

   vec_t tbl[$];

   initial begin
      // Single-cycle cases, all evaluated in RUN with no memory wait in progress.
      tbl.push_back(mk("idle",        1, 0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0));
      tbl.push_back(mk("lu_rs1",      1, 0, 1, 5'd5, 0, 5'd0, 0, 1, 5'd5, 0, 0, 0, 6'b000111, 1, 0, 0));
      tbl.push_back(mk("lu_rs2",      1, 0, 0, 5'd0, 1, 5'd7, 0, 1, 5'd7, 0, 0, 0, 6'b000111, 1, 0, 0));
      tbl.push_back(mk("lu_x0",       1, 0, 1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0));
      tbl.push_back(mk("lu_no_rden",  1, 0, 0, 5'd5, 0, 5'd5, 0, 1, 5'd5, 0, 0, 0, 6'b000000, 0, 0, 0));
      tbl.push_back(mk("not_load",    1, 0, 1, 5'd5, 1, 5'd5, 0, 0, 5'd5, 0, 0, 0, 6'b000000, 0, 0, 0));
      tbl.push_back(mk("lu_diff_reg", 1, 0, 1, 5'd6, 1, 5'd4, 0, 1, 5'd5, 0, 0, 0, 6'b000000, 0, 0, 0));
      tbl.push_back(mk("if_stall",    1, 1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 6'b000011, 0, 0, 0));
      tbl.push_back(mk("br_ifstall",  1, 1, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0, 0, 0, 0, 6'b000011, 0, 1, 0));
      tbl.push_back(mk("br_only",     1, 0, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 1, 0));
      tbl.push_back(mk("ex_busy",     1, 0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 0, 0));
      tbl.push_back(mk("exb_lu_br",   1, 0, 1, 5'd5, 0, 5'd0, 1, 1, 5'd5, 1, 0, 0, 6'b001111, 0, 0, 0));
      tbl.push_back(mk("lu_ifs_br",   1, 1, 1, 5'd9, 0, 5'd0, 1, 1, 5'd9, 0, 0, 0, 6'b000111, 1, 0, 0));
      tbl.push_back(mk("mem_ack_run", 1, 0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 6'b000000, 0, 0, 0));

      // Reset with active inputs: everything held low.
      apply(mk("reset0", 0, 1, 1, 5'd5, 0, 5'd0, 1, 1, 5'd5, 1, 1, 0, 6'b000000, 0, 0, 0));
      apply(memc("reset1", 0, 1, 0, 6'b000000, 0));

      foreach (tbl[i]) apply(tbl[i]);

      // Load-use costs one cycle; the load then moves to MEM.
      apply(mk("lu_seq0", 1, 0, 1, 5'd5, 0, 5'd1, 0, 1, 5'd5, 0, 0, 0, 6'b000111, 1, 0, 0));
      apply(mk("lu_seq1", 1, 0, 1, 5'd5, 0, 5'd1, 0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0));

      // ex_busy masks load-use and branch; once it drops the bubble follows, then the branch.
      apply(mk("exb_seq0", 1, 0, 1, 5'd5, 0, 5'd0, 1, 1, 5'd5, 1, 0, 0, 6'b001111, 0, 0, 0));
      apply(mk("exb_seq1", 1, 0, 1, 5'd5, 0, 5'd0, 1, 1, 5'd5, 1, 0, 0, 6'b001111, 0, 0, 0));
      apply(mk("exb_seq2", 1, 0, 1, 5'd5, 0, 5'd0, 1, 1, 5'd5, 0, 0, 0, 6'b000111, 1, 0, 0));
      apply(mk("exb_seq3", 1, 0, 1, 5'd5, 0, 5'd0, 1, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 1, 0));

      // Memory wait completed by ack after three wait cycles; mem_stall outranks ex_busy.
      apply(memc("ack_w1", 1, 1, 0, 6'b011111, 0));
      apply(mk("ack_w2_exb", 1, 0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 6'b011111, 0, 0, 0));
      apply(memc("ack_w3", 1, 1, 0, 6'b011111, 0));
      apply(memc("ack_done", 1, 1, 1, 6'b000000, 0));
      apply(memc("ack_after", 1, 0, 0, 6'b000000, 0));

      // Request withdrawn mid-wait: no error, and a later wait gets a full budget.
      apply(memc("drop_w1", 1, 1, 0, 6'b011111, 0));
      apply(memc("drop_w2", 1, 1, 0, 6'b011111, 0));
      apply(memc("drop_w3", 1, 1, 0, 6'b011111, 0));
      apply(memc("drop_rel", 1, 0, 0, 6'b000000, 0));
      apply(memc("drop_after", 1, 0, 0, 6'b000000, 0));

      // Watchdog: three held cycles, released on the fourth, flag sticky afterwards.
      apply(memc("wd_w1", 1, 1, 0, 6'b011111, 0));
      apply(memc("wd_w2", 1, 1, 0, 6'b011111, 0));
      apply(memc("wd_w3", 1, 1, 0, 6'b011111, 0));
      apply(memc("wd_fire", 1, 1, 0, 6'b000000, 0));
      apply(memc("wd_sticky0", 1, 0, 0, 6'b000000, 1));
      apply(mk("wd_sticky1", 1, 1, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0, 0, 0, 0, 6'b000011, 0, 1, 1));
      apply(memc("wd_sticky2", 1, 1, 1, 6'b000000, 1));

      // Reset clears the flag; reset mid-wait aborts without error and restarts the count.
      apply(memc("rst_clr", 0, 0, 0, 6'b000000, 0));
      apply(memc("rw_w1", 1, 1, 0, 6'b011111, 0));
      apply(memc("rw_w2", 1, 1, 0, 6'b011111, 0));
      apply(memc("rw_rst", 0, 1, 0, 6'b000000, 0));
      apply(memc("rw_w1b", 1, 1, 0, 6'b011111, 0));
      apply(memc("rw_w2b", 1, 1, 0, 6'b011111, 0));
      apply(memc("rw_w3b", 1, 1, 0, 6'b011111, 0));
      apply(memc("rw_fire", 1, 1, 0, 6'b000000, 0));
      apply(memc("rw_flag", 1, 0, 0, 6'b000000, 1));

      if (exp_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
